// File: rtl/dcnn_io_pkg.sv
// rtl/dcnn_io_pkg.sv - shared row width, byte field positions and controller state encoding
package dcnn_io_pkg;

    // Bits per feature-map row; bit ROW_W-1 is pixel 0.
    localparam int ROW_W   = 256;

    // Compressed byte layout: {value, run length}.
    localparam int VAL_BIT = 7;
    localparam int LEN_MSB = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FILL,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/decompress_ctrl_if.sv
// rtl/decompress_ctrl_if.sv - compressed byte stream in, assembled row stream out
// master: the decompression controller (consumes bytes, produces rows)
// slave:  the environment (produces bytes, consumes rows)
interface decompress_ctrl_if
    import dcnn_io_pkg::*;
#(
    parameter int ROW_W  = dcnn_io_pkg::ROW_W,
    parameter int ROWS_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ROW_W-1:0]  row_data;
    logic              row_valid;
    logic              row_ready;
    logic [ROWS_W-1:0] row_idx;

    modport master (
        input  in_data, in_valid, row_ready,
        output in_ready, row_data, row_valid, row_idx
    );

    modport slave (
        output in_data, in_valid, row_ready,
        input  in_ready, row_data, row_valid, row_idx
    );

endinterface

// File: rtl/decompress_fill_mask.sv
// rtl/decompress_fill_mask.sv - range mask for one run segment within a row
// Ports:
//   pos  : first pixel of the segment (pixel 0 is bit ROW_W-1)
//   n    : segment length in pixels
//   mask : ones on bits [ROW_W-1-pos : ROW_W-pos-n], zeros elsewhere
module decompress_fill_mask #(
    parameter int ROW_W = 256,
    parameter int POS_W = 9
) (
    input  logic [POS_W-1:0] pos,
    input  logic [POS_W-1:0] n,
    output logic [ROW_W-1:0] mask
);

    // One extra bit so pos+n == ROW_W does not wrap; a shift by ROW_W or
    // more yields zero, which makes the mask run to the LSB.
    logic [POS_W:0] stop;

    assign stop = {1'b0, pos} + {1'b0, n};
    assign mask = ({ROW_W{1'b1}} >> pos) & ~({ROW_W{1'b1}} >> stop);

endmodule

// File: rtl/decompress_ctrl.sv
// rtl/decompress_ctrl.sv - run-length decompression sequencer producing fixed-width rows
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start, num_rows : begin an image of num_rows rows (ignored while busy)
//   busy, done      : image in progress / one-cycle end-of-image pulse
//   err_tail        : sticky, a run still had pixels left at image end
//   io (master)     : in_data/in_valid/in_ready byte stream,
//                     row_data/row_valid/row_ready/row_idx row stream
module decompress_ctrl
    import dcnn_io_pkg::*;
#(
    parameter int ROW_W  = dcnn_io_pkg::ROW_W,
    parameter int RUN_W  = 7,
    parameter int ROWS_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROWS_W-1:0] num_rows,
    output logic              busy,
    output logic              done,
    output logic              err_tail,
    decompress_ctrl_if.master io
);

    localparam int POS_W = $clog2(ROW_W + 1);

    state_t            state;
    logic              run_val;
    logic [RUN_W-1:0]  run_rem;
    logic [POS_W-1:0]  pos;
    logic [ROWS_W-1:0] rows_left;
    logic [ROWS_W-1:0] row_idx;
    logic [ROW_W-1:0]  row_buf;
    logic              in_ready;
    logic              row_valid;

    logic [POS_W-1:0]  space;
    logic [POS_W-1:0]  seg_n;
    logic [POS_W-1:0]  end_pos;
    logic [ROW_W-1:0]  mask;
    logic [RUN_W-1:0]  in_len;

    assign in_len = io.in_data[LEN_MSB:0];

    // Segment written this FILL: the rest of the run, clipped at the row end.
    always_comb begin
        space   = POS_W'(ROW_W) - pos;
        seg_n   = (POS_W'(run_rem) < space) ? POS_W'(run_rem) : space;
        end_pos = pos + seg_n;
    end

    decompress_fill_mask #(
        .ROW_W (ROW_W),
        .POS_W (POS_W)
    ) u_fill_mask (
        .pos  (pos),
        .n    (seg_n),
        .mask (mask)
    );

    assign io.in_ready  = in_ready;
    assign io.row_valid = row_valid;
    assign io.row_data  = row_buf;
    assign io.row_idx   = row_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_val   <= 1'b0;
            run_rem   <= '0;
            pos       <= '0;
            rows_left <= '0;
            row_idx   <= '0;
            row_buf   <= '0;
            in_ready  <= 1'b0;
            row_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_tail  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_left <= num_rows;
                        pos       <= '0;
                        run_rem   <= '0;
                        row_idx   <= '0;
                        err_tail  <= 1'b0;
                        busy      <= 1'b1;
                        if (num_rows == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= FETCH;
                            in_ready <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    if (io.in_valid) begin
                        run_val <= io.in_data[VAL_BIT];
                        run_rem <= in_len;
                        // Zero-length bytes are swallowed here at one cycle each.
                        if (in_len != '0) begin
                            in_ready <= 1'b0;
                            state    <= FILL;
                        end
                    end
                end

                FILL: begin
                    row_buf <= (row_buf & ~mask) | (mask & {ROW_W{run_val}});
                    pos     <= end_pos;
                    run_rem <= run_rem - RUN_W'(seg_n);
                    if (end_pos == POS_W'(ROW_W)) begin
                        row_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= FETCH;
                    end
                end

                EMIT: begin
                    if (io.row_ready) begin
                        row_valid <= 1'b0;
                        rows_left <= rows_left - 1'b1;
                        row_idx   <= row_idx + 1'b1;
                        pos       <= '0;
                        if (rows_left == ROWS_W'(1)) begin
                            // Pulse done on entry so it follows the last handshake
                            // directly; err_tail must already be valid in that cycle.
                            done     <= 1'b1;
                            err_tail <= err_tail | (run_rem != '0);
                            state    <= DONE;
                        end else if (run_rem != '0) begin
                            state <= FILL;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end

                DONE: begin
                    // Entered from IDLE (empty image) with done low: spend one
                    // cycle raising it. Entered from EMIT it is already high.
                    if (done) begin
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        run_rem <= '0;
                        state   <= IDLE;
                    end else begin
                        done     <= 1'b1;
                        err_tail <= err_tail | (run_rem != '0);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decompress_ctrl.sv
// tb/tb_decompress_ctrl.sv - self-checking bench for decompress_ctrl
module tb_decompress_ctrl;
    import dcnn_io_pkg::*;

    localparam int RW = 256;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] num_rows;
    logic          busy;
    logic          done;
    logic          err_tail;

    decompress_ctrl_if #(.ROW_W(RW), .ROWS_W(NW)) io ();

    decompress_ctrl #(
        .ROW_W  (RW),
        .RUN_W  (7),
        .ROWS_W (NW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_rows (num_rows),
        .busy     (busy),
        .done     (done),
        .err_tail (err_tail),
        .io       (io.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]    byte_q[$];
    logic [RW-1:0] exp_rows[$];
    logic          exp_err;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expand every byte into its pixels, cut the pixel stream into rows.
    // Pixels beyond the last row mean a run was left over at image end.
    task automatic build_model(input int nrows);
        logic          bits[$];
        logic [7:0]    b;
        logic [RW-1:0] row;
        exp_rows.delete();
        foreach (byte_q[i]) begin
            b = byte_q[i];
            for (int k = 0; k < int'(b[6:0]); k++) bits.push_back(b[7]);
        end
        for (int r = 0; r < nrows; r++) begin
            row = '0;
            for (int i = 0; i < RW; i++)
                if (r * RW + i < bits.size()) row[RW-1-i] = bits[r * RW + i];
            exp_rows.push_back(row);
        end
        exp_err = (bits.size() > nrows * RW);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"},      busy,         0);
        check({pfx, "_done"},      done,         0);
        check({pfx, "_err_tail"},  err_tail,     0);
        check({pfx, "_in_ready"},  io.in_ready,  0);
        check({pfx, "_row_valid"}, io.row_valid, 0);
        check({pfx, "_row_data"},  io.row_data,  0);
        check({pfx, "_row_idx"},   io.row_idx,   0);
    endtask

    // Runs one image from byte_q. hold>0 keeps row_ready low for exactly
    // hold cycles on every row; otherwise row_ready is random.
    task automatic run_image(input int nrows, input int vld_pct, input int rdy_pct,
                             input int hold, output int done_cyc);
        int            cyc;
        int            rows_seen;
        int            last_hs;
        int            held;
        bit            got_done;
        bit            fire_in;
        bit            fire_row;
        logic [RW-1:0] snap;
        build_model(nrows);
        rows_seen = 0;
        last_hs   = -1;
        held      = 0;
        got_done  = 0;
        done_cyc  = -1;
        snap      = '0;
        @(negedge clk);
        start       = 1'b1;
        num_rows    = NW'(nrows);
        io.in_valid = 1'b0;
        io.row_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("start_clears_err_tail", err_tail, 0);
        check("busy_after_start", busy, 1);
        while (cyc < 20000 && !got_done) begin
            check("in_ready_row_valid_exclusive", io.in_ready & io.row_valid, 0);
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                break;
            end
            io.in_valid = (byte_q.size() > 0) && ($urandom_range(99) < vld_pct);
            io.in_data  = (byte_q.size() > 0) ? byte_q[0] : 8'($urandom);
            if (hold > 0) io.row_ready = (held >= hold);
            else          io.row_ready = ($urandom_range(99) < rdy_pct);
            if (io.row_valid && !io.row_ready) begin
                if (held == 0) snap = io.row_data;
                else check("bp_row_stable", io.row_data, snap);
                check("bp_in_ready_low", io.in_ready, 0);
                held++;
            end
            fire_in  = io.in_ready && io.in_valid;
            fire_row = io.row_valid && io.row_ready;
            if (fire_row) begin
                if (rows_seen < exp_rows.size()) begin
                    check($sformatf("row%0d_data", rows_seen), io.row_data, exp_rows[rows_seen]);
                    check($sformatf("row%0d_idx", rows_seen), io.row_idx, rows_seen);
                end else begin
                    check("row_count_overrun", rows_seen, exp_rows.size());
                end
                if (hold > 0) check("bp_hold_cycles", held, hold);
                rows_seen++;
                last_hs = cyc;
                held    = 0;
            end
            if (fire_in) void'(byte_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        check("done_seen", got_done, 1);
        check("rows_emitted", rows_seen, nrows);
        check("bytes_consumed", byte_q.size(), 0);
        check("busy_in_done_cycle", busy, 1);
        check("err_tail_at_done", err_tail, exp_err);
        if (nrows > 0) check("done_after_last_handshake", done_cyc, last_hs + 1);
        io.in_valid  = 1'b0;
        io.row_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_drops", busy, 0);
        byte_q.delete();
    endtask

    initial begin
        int  c1;
        int  c3;
        int  cx;
        int  nr;
        int  total;
        bit  acc;
        logic [7:0] b;

        rst_n        = 1'b0;
        start        = 1'b0;
        num_rows     = '0;
        io.in_data   = '0;
        io.in_valid  = 1'b0;
        io.row_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Full-ones row.
        byte_q = '{8'hFF, 8'hFF, 8'h82};
        run_image(1, 100, 100, 0, c1);
        check("full_ones_latency", c1, 8);

        // Run spanning a row boundary.
        byte_q = '{8'h7F, 8'h7F, 8'h85, 8'h7F, 8'h7E};
        check("span_model_row0", {255'd0, 1'b1} | {254'd0, 2'b10}, 256'h3);
        run_image(2, 100, 100, 0, cx);

        // Zero-length bytes between every byte: one extra cycle each.
        byte_q = '{8'hFF, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h80, 8'h82};
        run_image(1, 100, 100, 0, c3);
        check("zero_byte_cost", c3 - c1, 4);

        // Backpressure: ten cycles of row_ready low per row.
        byte_q = '{8'hFF, 8'hFF, 8'h82};
        run_image(1, 100, 100, 10, cx);
        byte_q = '{8'h7F, 8'h7F, 8'h85, 8'h7F, 8'h7E};
        run_image(2, 100, 100, 10, cx);

        // Trailing run left over at image end.
        byte_q = '{8'hFF, 8'hFF, 8'h85};
        run_image(1, 100, 100, 0, cx);

        // Random images with random stalls on both sides.
        for (int img = 0; img < 6; img++) begin
            nr    = $urandom_range(1, 3);
            total = 0;
            while (total < nr * RW) begin
                b = 8'($urandom);
                byte_q.push_back(b);
                total += int'(b[6:0]);
            end
            run_image(nr, 70, 60, 0, cx);
        end

        // Reset while filling.
        @(negedge clk);
        start    = 1'b1;
        num_rows = 16'd1;
        @(negedge clk);
        start       = 1'b0;
        io.in_data  = 8'hFF;
        io.in_valid = 1'b1;
        acc         = io.in_ready;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = io.in_ready;
        end
        check("rst_fill_byte_accepted", acc, 1);
        @(negedge clk);
        io.in_valid = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_in_fill");
        rst_n = 1'b1;

        // Empty image: done two cycles after start, no rows.
        run_image(0, 100, 100, 0, cx);
        check("empty_done_latency", cx, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
